// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port and the load/store port.
// Latency: read accept -> rvalid is MEM_LAT+2 cycles; a write is committed one cycle after accept.
// Backpressure: *_ready only in IDLE, at most one winner per cycle, round-robin on ties.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_if_req,
   input  logic [AW-1:0] i_if_addr,
   output logic          o_if_ready,
   output logic          o_if_rvalid,
   output logic [DW-1:0] o_if_rdata,
   input  logic          i_d_req,
   input  logic          i_d_we,
   input  logic [AW-1:0] i_d_addr,
   input  logic [DW-1:0] i_d_wdata,
   output logic          o_d_ready,
   output logic          o_d_rvalid,
   output logic [DW-1:0] o_d_rdata,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   // Owner / last-grant encoding: 0 = fetch port, 1 = data port.
   localparam logic       OWN_IF  = 1'b0;
   localparam logic       OWN_D   = 1'b1;
   localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

   state_t        r_state;
   state_t        w_next;
   logic          r_last_grant;
   logic          r_owner;
   logic          r_we;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_d_rdata;
   logic          w_grant_if;
   logic          w_grant_d;
   logic          w_accept;
   logic          w_capture;

   // Arbitration in IDLE and next-state selection; grants are masked while reset is high.
   always_comb begin
      w_next     = r_state;
      w_grant_if = 1'b0;
      w_grant_d  = 1'b0;
      w_capture  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!i_rst) begin
               // Data wins when alone, or on a tie when fetch was granted last.
               if (i_d_req && (!i_if_req || (r_last_grant == OWN_IF))) begin
                  w_grant_d = 1'b1;
               end else if (i_if_req) begin
                  w_grant_if = 1'b1;
               end
               if (w_grant_d || w_grant_if) begin
                  w_next = S_ISSUE;
               end
            end
         end
         S_ISSUE: w_next = r_we ? S_IDLE : S_WAIT;
         S_WAIT: begin
            // cnt==1 marks the cycle in which the memory's read word is valid.
            if (r_cnt == 4'd1) begin
               w_capture = 1'b1;
               w_next    = S_RESP;
            end
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_accept = w_grant_if | w_grant_d;

   // State, request latch, wait counter and response capture; reset drops any in-flight read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= OWN_IF;
         r_owner      <= OWN_IF;
         r_we         <= 1'b0;
         r_cnt        <= 4'd0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_if_rdata   <= '0;
         r_d_rdata    <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_last_grant <= w_grant_d ? OWN_D : OWN_IF;
            r_owner      <= w_grant_d ? OWN_D : OWN_IF;
            r_we         <= w_grant_d & i_d_we;
            r_addr       <= w_grant_d ? i_d_addr : i_if_addr;
            if (w_grant_d) begin
               r_wdata <= i_d_wdata;
            end
         end
         if ((r_state == S_ISSUE) && !r_we) begin
            r_cnt <= LAT_CNT;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            if (r_owner == OWN_D) begin
               r_d_rdata <= i_mem_rdata;
            end else begin
               r_if_rdata <= i_mem_rdata;
            end
         end
      end
   end

   assign o_if_ready  = w_grant_if;
   assign o_d_ready   = w_grant_d;
   assign o_mem_req   = (r_state == S_ISSUE);
   assign o_mem_we    = (r_state == S_ISSUE) & r_we;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_if_rvalid = (r_state == S_RESP) & (r_owner == OWN_IF);
   assign o_d_rvalid  = (r_state == S_RESP) & (r_owner == OWN_D);
   assign o_if_rdata  = r_if_rdata;
   assign o_d_rdata   = r_d_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the core's instruction-fetch port and its load/store port. Sits between `core` and the memory model or SRAM wrapper. Only one access is in flight at a time. Simultaneous requesters are served round-robin, and each requester sees a ready/rvalid handshake, so the core stalls on contention.

## Interface
- `AW`, 32: address width (byte address, passed through unmodified)
- `DW`, 32: data width
- `MEM_LAT`, 1: cycles from the `mem_req` cycle to `mem_rdata` being valid; legal range 1..15
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset; one clock; reset is synchronous and active-high
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_ready`
- `if_addr` in AW: fetch address
- `if_ready` out 1: fetch accepted this cycle (combinational)
- `if_rvalid` out 1: one-cycle pulse, `if_rdata` valid
- `if_rdata` out DW: fetched word
- `d_req` in 1: data request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_ready`
- `d_we` in 1: 1 = write, 0 = read
- `d_addr` in AW: data address
- `d_wdata` in DW: write data
- `d_ready` out 1: data request accepted this cycle (combinational)
- `d_rvalid` out 1: one-cycle pulse for reads only, `d_rdata` valid
- `d_rdata` out DW: read data
- `mem_req` out 1: memory access strobe, one cycle per access
- `mem_we` out 1: write strobe, qualified by `mem_req`
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory write data
- `mem_rdata` in DW: memory read data, valid exactly `MEM_LAT` cycles after the `mem_req` cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any request is pending, pick a winner and assert its `*_ready` combinationally.
  - Latch the winner's addr/we/wdata and the winner's identity into registers.
  - Go to ISSUE.
- **Arbitration**
  - Only one request pending: it wins.
  - Both pending: the requester not granted last wins.
  - `last_grant` resets to IF, so data wins the first tie after reset.
  - `last_grant` updates on every accept.
- **ISSUE**
  - `mem_req`=1, with `mem_we`/`mem_addr`/`mem_wdata` driven from the latched registers.
  - Write: go to IDLE.
  - Read: load `cnt`=`MEM_LAT` and go to WAIT.
- **WAIT**
  - Decrement `cnt` each cycle.
  - In the cycle where `cnt`==1, capture `mem_rdata` into the response register and go to RESP.
- **RESP**
  - Pulse `if_rvalid` or `d_rvalid` according to the latched owner; the rdata output holds the captured word.
  - Go to IDLE.
- `*_ready` is never asserted outside IDLE, and never to both requesters in the same cycle.
- `if_rdata`/`d_rdata` hold their last captured value until the next capture; they are only meaningful while rvalid is high.
- Writes produce no rvalid. The write is committed at the ISSUE cycle.
- Requests withdrawn before ready are legal and are simply not served. Changing a request's address before ready is not checked.
- `cnt` width is 4 bits.
- `mem_addr` is not aligned or checked. Misaligned addresses are forwarded as-is.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = IF, `cnt` = 0.
  - `mem_req`, `mem_we`, `if_rvalid`, `d_rvalid` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
  - `if_ready` and `d_ready` = 0 in any cycle where `rst` is high.
- Read accepted in cycle A:
  - `mem_req` at A+1.
  - `mem_rdata` sampled at A+1+`MEM_LAT`.
  - rvalid at A+2+`MEM_LAT`.
  - Next accept no earlier than A+3+`MEM_LAT`.
- Write accepted in cycle A: `mem_req`/`mem_we` at A+1, next accept no earlier than A+2.
- Back-to-back throughput:
  - Reads: one per `MEM_LAT`+3 cycles.
  - Writes: one per 2 cycles.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - A pending rvalid is dropped and is never delivered.
  - An in-flight `mem_rdata` is ignored.
- A new request arriving in the same cycle as RESP is not accepted until the following (IDLE) cycle.

## Test plan
1. Single fetch, `MEM_LAT`=1:
   - Stimulus: `if_req` with `if_addr`=0x10, memory returns 0x8C080010.
   - Required: `if_ready` at A; `mem_req`=1, `mem_we`=0, `mem_addr`=0x10 at A+1; `if_rvalid`=1 with `if_rdata`=0x8C080010 at A+3; no `d_rvalid`.
2. Data write:
   - Stimulus: `d_req`, `d_we`=1, `d_addr`=0x8, `d_wdata`=100.
   - Required: `d_ready` at A; `mem_req`=`mem_we`=1, `mem_addr`=0x8, `mem_wdata`=100 at A+1; no `d_rvalid`; a held `if_req` is accepted at A+2.
3. Contention after reset:
   - Stimulus: `if_req` and `d_req` (read) both held from the first cycle after reset.
   - Required: data accepted first at A; fetch accepted at A+4; grants alternate D, IF, D, IF while both are held.
4. Fetch stream only:
   - Stimulus: `if_req` held continuously, `MEM_LAT`=1.
   - Required: accepts every 4 cycles, rvalid every 4 cycles; `d_ready` never high.
5. Reset mid-read:
   - Stimulus: `rst` asserted during WAIT, `MEM_LAT`=3.
   - Required: all outputs 0 the next cycle; no rvalid ever for that access; after release, a tie goes to data.
6. `MEM_LAT`=3 data read:
   - Stimulus: `d_addr`=0x4, memory returns 0x64.
   - Required: `mem_req` at A+1; `d_rvalid` with `d_rdata`=0x64 at A+5; next accept at A+6.
